// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter/sequencer loading one shared DATA_W-bit register,
// with optional locked bursts of up to MAX_BURST beats per grant.
module shared_reg_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          lock,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]           q,
  output logic                        q_valid,
  output logic [$clog2(NUM_REQ)-1:0]  q_src
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    owner, owner_n;
  logic [IDX_W-1:0]    ptr, ptr_n;
  logic [BCNT_W-1:0]   bcnt, bcnt_n;
  logic [NUM_REQ-1:0]  gnt_n;
  logic [DATA_W-1:0]   q_n;
  logic                q_valid_n;
  logic [IDX_W-1:0]    q_src_n;

  logic                rel;
  logic                arb;
  logic                found;
  logic [IDX_W-1:0]    start;
  logic [IDX_W-1:0]    win;
  logic [IDX_W-1:0]    cand;

  // Index i+k wrapped modulo NUM_REQ (works for non-power-of-two counts).
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] i,
                                                input int unsigned k);
    int unsigned s;
    s = 32'(i) + k;
    return IDX_W'(s % NUM_REQ);
  endfunction

  // State and datapath registers; async reset clears everything mid-burst.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      owner   <= '0;
      ptr     <= '0;
      bcnt    <= '0;
      gnt     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      q_src   <= '0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      ptr     <= ptr_n;
      bcnt    <= bcnt_n;
      gnt     <= gnt_n;
      q       <= q_n;
      q_valid <= q_valid_n;
      q_src   <= q_src_n;
    end
  end

  // Beat/release decision, then round-robin search from ptr (or owner+1 on release).
  always_comb begin
    state_n   = state;
    owner_n   = owner;
    ptr_n     = ptr;
    bcnt_n    = bcnt;
    gnt_n     = gnt;
    q_n       = q;
    q_valid_n = 1'b0;
    q_src_n   = q_src;
    rel       = 1'b0;
    arb       = (state == IDLE);
    found     = 1'b0;
    start     = ptr;
    win       = '0;
    cand      = '0;

    if (state == OWN) begin
      if (!req[owner]) begin
        rel = 1'b1;
      end else begin
        q_n       = wdata[32'(owner)*DATA_W +: DATA_W];
        q_src_n   = owner;
        q_valid_n = 1'b1;
        if (!lock[owner] || (bcnt == BCNT_W'(MAX_BURST - 1))) begin
          rel = 1'b1;
        end else begin
          bcnt_n = bcnt + BCNT_W'(1);
        end
      end
    end

    if (rel) begin
      start = wrap_add(owner, 1);
      ptr_n = start;
      arb   = 1'b1;
    end

    if (arb) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = wrap_add(start, k);
        if (!found && req[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
      if (found) begin
        state_n = OWN;
        owner_n = win;
        gnt_n   = NUM_REQ'(1) << win;
        bcnt_n  = '0;
      end else begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: a vector table for the round-robin
// and abort/re-grant flow, plus hand sequences for reset, bursts and abort.
module tb_shared_reg_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 8;

  logic                       clk;
  logic                       reset;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ-1:0]         lock;
  logic [NUM_REQ*DATA_W-1:0]  wdata;
  logic [NUM_REQ-1:0]         gnt;
  logic [DATA_W-1:0]          q;
  logic                       q_valid;
  logic [1:0]                 q_src;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        v;
    logic [1:0]  src;
  } vec_t;

  vec_t vecs [9];

  shared_reg_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .lock    (lock),
    .wdata   (wdata),
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid),
    .q_src   (q_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eg, input logic [7:0] eq,
                         input logic ev, input logic [1:0] es);
    total++;
    if (gnt !== eg) begin bad++; $display("FAIL %s gnt: got %b want %b", tag, gnt, eg); end
    total++;
    if (q !== eq) begin bad++; $display("FAIL %s q: got %h want %h", tag, q, eq); end
    total++;
    if (q_valid !== ev) begin bad++; $display("FAIL %s q_valid: got %b want %b", tag, q_valid, ev); end
    total++;
    if (q_src !== es) begin bad++; $display("FAIL %s q_src: got %0d want %0d", tag, q_src, es); end
  endtask

  initial begin
    // Row order continues from a fresh reset (ptr=0, IDLE).
    // Full contention, lock=0: strict rotation, one beat per cycle.
    vecs[0] = '{4'b1111, 4'b0000, 32'h13121110, 4'b0001, 8'h00, 1'b0, 2'd0};
    vecs[1] = '{4'b1111, 4'b0000, 32'h13121110, 4'b0010, 8'h10, 1'b1, 2'd0};
    vecs[2] = '{4'b1111, 4'b0000, 32'h13121110, 4'b0100, 8'h11, 1'b1, 2'd1};
    vecs[3] = '{4'b1111, 4'b0000, 32'h13121110, 4'b1000, 8'h12, 1'b1, 2'd2};
    vecs[4] = '{4'b1111, 4'b0000, 32'h13121110, 4'b0001, 8'h13, 1'b1, 2'd3};
    // Owner 0 drops req: abort with no write, grant moves to 2 (only requester).
    vecs[5] = '{4'b0100, 4'b0000, 32'h13A51110, 4'b0100, 8'h13, 1'b0, 2'd3};
    // Beat from 2; 2 is alone so it is re-granted with no gap.
    vecs[6] = '{4'b0100, 4'b0000, 32'h13A51110, 4'b0100, 8'hA5, 1'b1, 2'd2};
    // Requests gone: abort, then idle; q/q_src hold.
    vecs[7] = '{4'b0000, 4'b0000, 32'h13A51110, 4'b0000, 8'hA5, 1'b0, 2'd2};
    vecs[8] = '{4'b0000, 4'b0000, 32'h13A51110, 4'b0000, 8'hA5, 1'b0, 2'd2};

    reset = 1'b0;
    req   = '0;
    lock  = '0;
    wdata = '0;

    // Held in reset: toggling inputs must not disturb outputs.
    #1;
    chk_all("rst_async", 4'b0000, 8'h00, 1'b0, 2'd0);
    for (int k = 0; k < 4; k++) begin
      req   = 4'(k * 5 + 3);
      wdata = 32'hDEAD0000 + 32'(k);
      lock  = 4'(k);
      tick();
      chk_all($sformatf("rst_hold%0d", k), 4'b0000, 8'h00, 1'b0, 2'd0);
    end
    req   = '0;
    lock  = '0;
    wdata = '0;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk_all($sformatf("post_rst_idle%0d", k), 4'b0000, 8'h00, 1'b0, 2'd0);
    end

    // Table-driven vectors.
    for (int i = 0; i < 9; i++) begin
      req   = vecs[i].req;
      lock  = vecs[i].lock;
      wdata = vecs[i].wdata;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].q, vecs[i].v, vecs[i].src);
    end

    // Fresh pointer for the burst sequence.
    reset = 1'b0;
    #2;
    reset = 1'b1;

    // Locked burst from 1 capped at 4 beats, then 3 follows with no gap.
    req   = 4'b1010;
    lock  = 4'b0010;
    wdata = 32'h33000000;
    tick();
    chk_all("burst_gnt", 4'b0010, 8'h00, 1'b0, 2'd0);
    for (int k = 1; k <= 4; k++) begin
      wdata[8 +: 8] = 8'(k);
      tick();
      chk_all($sformatf("burst_beat%0d", k), (k < 4) ? 4'b0010 : 4'b1000, 8'(k), 1'b1, 2'd1);
    end
    wdata[8 +: 8] = 8'd5;
    tick();
    chk_all("burst_next_owner", 4'b0010, 8'h33, 1'b1, 2'd3);

    // Async reset mid-burst clears outputs before the next edge.
    wdata[8 +: 8] = 8'd6;
    tick();
    chk_all("burst2_beat1", 4'b0010, 8'h06, 1'b1, 2'd1);
    reset = 1'b0;
    #2;
    chk_all("midburst_rst", 4'b0000, 8'h00, 1'b0, 2'd0);
    tick();
    chk_all("midburst_rst_hold", 4'b0000, 8'h00, 1'b0, 2'd0);
    reset = 1'b1;
    req   = 4'b1111;
    lock  = 4'b0000;
    wdata = 32'hC3000000;
    tick();
    chk_all("rst_ptr0", 4'b0001, 8'h00, 1'b0, 2'd0);

    // Granted requester 0 withdraws: no write, grant passes to 3.
    req = 4'b1000;
    tick();
    chk_all("abort0", 4'b1000, 8'h00, 1'b0, 2'd0);
    tick();
    chk_all("abort_next_beat", 4'b1000, 8'hC3, 1'b1, 2'd3);
    req = 4'b0000;
    tick();
    chk_all("final_idle", 4'b0000, 8'hC3, 1'b0, 2'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Grant must never have more than one bit set.
  always @(negedge clk) begin
    if (reset && !$isunknown(gnt) && !$onehot0(gnt)) begin
      bad++;
      $display("FAIL gnt_onehot: got %b want one-hot or zero", gnt);
    end
  end

endmodule
